// File: rtl/cpu_pipe.sv
// A-RISC pipelined core: fetch overlapped with decode/execute, one instruction per clock.
// DRAM req/ack handshake with stalls, optional branch delay slot, retired counter.
module cpu_pipe #(
    parameter int W            = 8,
    parameter int NUM_GPR      = 8,
    parameter int IAW          = 8,
    parameter int BRANCH_DELAY = 0,
    parameter int CW           = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    output logic           idle,
    output logic [IAW-1:0] iram_addr,
    input  logic [15:0]    iram_dout,
    output logic           dram_req,
    output logic           dram_write,
    input  logic           dram_ack,
    output logic [W-1:0]   dram_addr,
    output logic [W-1:0]   dram_din,
    input  logic [W-1:0]   dram_dout,
    output logic [CW-1:0]  retired
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DV2 = 4'd4;
    localparam logic [3:0] OP_LDM = 4'd5;
    localparam logic [3:0] OP_STM = 4'd6;
    localparam logic [3:0] OP_MVR = 4'd7;
    localparam logic [3:0] OP_MVI = 4'd8;
    localparam logic [3:0] OP_BEQ = 4'd9;
    localparam logic [3:0] OP_BLT = 4'd10;
    localparam logic [3:0] OP_END = 4'd11;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         state_q, state_d;
    logic [IAW-1:0] pc_q, pc_d, pc_next;
    logic [IAW-1:0] tgt_q, tgt_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   di_q, di_d;
    logic [W-1:0]   ar_q, ar_d;
    logic [W-1:0]   jr_q, jr_d;
    logic [W-1:0]   gpr_q [NUM_GPR];
    logic [W-1:0]   gpr_d [NUM_GPR];
    logic [CW-1:0]  ret_q, ret_d;

    logic [3:0]     op, rd, ra, rb;
    logic [W-1:0]   imm, pc1, va, vb, alu;
    logic [W-1:0]   rf [16];
    logic signed [W-1:0] dv_t;
    logic           run, is_mem, stall, done, wr_en, taken, is_end;
    logic           redir;
    logic [IAW-1:0] redir_tgt;

    assign op     = iram_dout[3:0];
    assign rd     = iram_dout[7:4];
    assign ra     = iram_dout[11:8];
    assign rb     = iram_dout[15:12];
    assign imm    = W'($signed({ra, rb}));
    assign pc1    = W'(pc_q + IAW'(1));
    assign run    = (state_q == S_RUN);
    assign is_end = run && (op == OP_END);
    assign is_mem = run && (op == OP_LDM || op == OP_STM);
    assign stall  = is_mem && !dram_ack;
    assign done   = run && !stall;

    // Unified read view of the register map; unmapped addresses read 0.
    always_comb begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        rf[1] = W'(1);
        rf[2] = di_q;
        rf[3] = imm;
        rf[4] = ar_q;
        rf[5] = jr_q;
        rf[6] = pc1;
        for (int i = 0; i < NUM_GPR; i++) rf[7+i] = gpr_q[i];
    end

    assign va = rf[ra];
    assign vb = rf[rb];

    always_comb begin
        alu   = '0;
        wr_en = 1'b0;
        taken = 1'b0;
        dv_t  = $signed(va + {{(W-1){1'b0}}, va[W-1]});
        case (op)
            OP_ADD: begin alu = va + vb; wr_en = run; end
            OP_SUB: begin alu = va - vb; wr_en = run; end
            OP_MUL: begin alu = va * vb; wr_en = run; end
            OP_DV2: begin alu = dv_t >>> 1; wr_en = run; end
            OP_MVR: begin alu = va; wr_en = run; end
            OP_MVI: begin alu = imm; wr_en = run; end
            OP_BEQ: taken = run && (va == vb);
            OP_BLT: taken = run && ($signed(va) < $signed(vb));
            default: ;
        endcase
    end

    // In delay-slot mode the latched target is used; a branch in the slot is ignored.
    always_comb begin
        if (BRANCH_DELAY != 0) begin
            redir     = pend_q;
            redir_tgt = tgt_q;
        end else begin
            redir     = taken;
            redir_tgt = IAW'(jr_q);
        end
        if (is_end)     pc_next = '0;
        else if (stall) pc_next = pc_q;
        else if (redir) pc_next = redir_tgt;
        else            pc_next = pc_q + IAW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (done && is_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idle       = (state_q == S_IDLE);
        iram_addr  = run ? pc_next : '0;
        dram_req   = is_mem;
        dram_write = is_mem && (op == OP_STM);
        dram_addr  = ar_q;
        dram_din   = va;
        retired    = ret_q;
    end

    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        tgt_d  = tgt_q;
        ret_d  = ret_q;
        di_d   = di_q;
        ar_d   = ar_q;
        jr_d   = jr_q;
        for (int i = 0; i < NUM_GPR; i++) gpr_d[i] = gpr_q[i];
        if (!run) begin
            pc_d = '0;
            if (start) ret_d = '0;
        end else begin
            pc_d = pc_next;
            if (done) ret_d = ret_q + CW'(1);
            if (BRANCH_DELAY != 0 && done) begin
                if (is_end || pend_q) begin
                    pend_d = 1'b0;
                end else if (taken) begin
                    pend_d = 1'b1;
                    tgt_d  = IAW'(jr_q);
                end
            end
            if (done && op == OP_LDM) di_d = dram_dout;
            if (done && wr_en) begin
                case (rd)
                    4'd4: ar_d = alu;
                    4'd5: jr_d = alu;
                    default: begin
                        for (int i = 0; i < NUM_GPR; i++)
                            if (rd == 4'(7 + i)) gpr_d[i] = alu;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= '0;
            pend_q <= 1'b0;
            tgt_q  <= '0;
            ret_q  <= '0;
            di_q   <= '0;
            ar_q   <= '0;
            jr_q   <= '0;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
            ret_q  <= ret_d;
            di_q   <= di_d;
            ar_q   <= ar_d;
            jr_q   <= jr_d;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
        end
    end

endmodule

// File: doc/cpu_pipe.md
Name: cpu_pipe

Overview:
- Next-generation A-RISC core: same 16-bit ISA and register map as the existing cpu, parametrised in datapath width and GPR count.
- Overlaps fetch with decode/execute, so it sustains one instruction per clock.
- Adds a req/ack DRAM handshake with stalls, a selectable branch-delay mode and a retired-instruction counter.
- Sits between the IRAM (synchronous read, 1-cycle latency) and the DRAM/peripheral bus.

Parameters:
W, 8, datapath/register/DRAM width; legal values are 8 or more.
NUM_GPR, 8, general-purpose registers R7..R(6+NUM_GPR); legal range 1..9.
IAW, 8, IRAM address width.
BRANCH_DELAY, 0, 1 = one delay slot after a taken branch (legacy semantics); 0 = no delay slot.
CW, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin execution at address 0; sampled only while idle
idle  out  1  core halted
iram_addr  out  IAW  IRAM read address
iram_dout  in  16  instruction word {rb,ra,rd,opcode}, valid one cycle after its address
dram_req  out  1  DRAM access request
dram_write  out  1  1 = store, 0 = load; valid while dram_req is high
dram_ack  in  1  access completes this cycle
dram_addr  out  W  DRAM address (AR)
dram_din  out  W  store data R[ra]
dram_dout  in  W  load data, valid when dram_ack is high
retired  out  CW  instructions completed since the last start

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset values: state=IDLE, idle=1, iram_addr=0, dram_req=0, dram_write=0, retired=0, all registers 0, pending delay-slot flag=0.
- Reset asserted mid-access drops dram_req immediately.
- Opcode encodings: NOP0 ADD1 SUB2 MUL3 DV2 4 LDM5 STM6 MVR7 MVI8 BEQ9 BLT10 END11. Opcodes 12-15 execute as NOP.
- Register map: R0=0, R1=1, R2=DI, R3=IM, R4=AR, R5=JR, R6=pc+1, R7+ = GPRs.
- Writes to R0-R3 and R6 are discarded. Reads of addresses ≥7+NUM_GPR return 0.
- IM is {ra,rb}, sign-extended to W.
- ALU results:
  - ADD/SUB/MUL: low W bits, two's complement.
  - DV2: signed divide by 2, truncated toward zero (-3 → -1).
  - MVR passes R[ra]. MVI passes IM.
- Branches, target JR:
  - BEQ is taken when R[ra]==R[rb].
  - BLT is taken when signed R[ra]<R[rb], using a full comparison with no overflow error.
- State machine IDLE/RUN:
  - IDLE: iram_addr=0. start → RUN next edge, with pc=0. The first instruction executes in the first RUN cycle.
  - RUN: the instruction on iram_dout (address pc) executes; register writeback occurs at the end of the cycle.
  - iram_addr = pc_next, selected in this priority order: END → 0; stall → pc; redirect → JR; else pc+1.
- Redirect timing:
  - BRANCH_DELAY=0: redirect happens in the same cycle the branch is taken.
  - BRANCH_DELAY=1: a taken branch sets a pending flag. The following instruction executes, then redirect happens at its pc_next.
  - If the delay-slot instruction is itself a taken branch, the older target wins and the new branch is ignored.
- LDM/STM:
  - dram_req is asserted combinationally in the execute cycle, with dram_addr=AR and dram_din=R[ra].
  - The core stalls (pc, registers and retired all hold; iram_addr=pc) until dram_ack is high.
  - On the ack cycle: LDM latches DI←dram_dout, and the instruction completes.
  - Zero-wait ack in the same cycle as the request is legal. dram_ack is ignored while dram_req=0.
- END: completes, retired increments, next state is IDLE. The pending delay-slot flag is cleared.
- start: ignored in RUN. A start pulse while idle clears retired.
- Retired counter: increments once per completed instruction, including NOP and END. It never counts stall cycles and wraps at 2^CW.

Test Plan:
- MVI R7,5; MVI R8,3; ADD R9,R7,R8; MUL R10,R9,R9; END → R9=8, R10=64 (low 8 bits); retired=5; 6 cycles from start to idle=1.
- MVI R7,-3; DV2 R8,R7; BLT with R7=-128 vs R8=1 → R8=-1; branch taken despite subtraction overflow.
- BRANCH_DELAY=0, JR=10, BEQ R0,R0 at addr 2 → next iram_addr=10; the instruction at addr 3 never executes. With BRANCH_DELAY=1 → addr 3 executes, then 10.
- LDM with AR=0x20, dram_ack held low 3 cycles → dram_req high for 4 cycles; iram_addr frozen; DI=dram_dout sampled on the ack cycle; retired +1 only once.
- STM with zero-wait ack → dram_req=1, dram_write=1 for one cycle; dram_din=R[ra]; no stall cycle.
- Assert rstn=0 during an LDM wait → dram_req=0 immediately; idle=1; registers 0; a subsequent start restarts at addr 0 with retired=0.
